unpack_stage: RTL and testbench

UNPACK_STAGE -- requirements
Module: unpack_stage

---
 rtl/float_types_pkg.sv | 34 +++
 rtl/fp_classify.sv | 59 +++++
 rtl/unpack_stage.sv | 105 ++++++++++
 tb/tb_unpack_stage.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_types_pkg.sv
// Shared floating-point operand types for the unpack stage.
// Encodings keep ZERO / ZERO_RES at all-zero bits so a cleared payload reads as the reset state.
package float_types_pkg;

   typedef enum logic [2:0] {
      ZERO    = 3'd0,
      SUBNORM = 3'd1,
      NORMAL  = 3'd2,
      INF     = 3'd3,
      NAN     = 3'd4
   } fp_class_t;

   typedef enum logic [1:0] {
      ZERO_RES   = 2'd0,
      INF_OR_NAN = 2'd1,
      OK_state   = 2'd2
   } num_status_t;

   localparam int CLASS_W  = $bits(fp_class_t);
   localparam int STATUS_W = $bits(num_status_t);

   // Special operands dominate; otherwise a pair of zeros yields a zero result.
   function automatic num_status_t pair_status(input fp_class_t a_cls, input fp_class_t b_cls);
      num_status_t st;
      st = OK_state;
      if ((a_cls == INF) || (a_cls == NAN) || (b_cls == INF) || (b_cls == NAN)) begin
         st = INF_OR_NAN;
      end else if ((a_cls == ZERO) && (b_cls == ZERO)) begin
         st = ZERO_RES;
      end
      return st;
   endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational per-operand classify/unpack: splits {sign, exp, frac}, restores the hidden bit.
// UNPACK_SUBNORM_EN keeps subnormals (exp forced to 1); otherwise they flush to signed zero.
module fp_classify
   import float_types_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23
) (
   input  logic [EXP_W+MANT_W:0] i_op,
   output logic                  o_sign,
   output logic [EXP_W-1:0]      o_exp,
   output logic [MANT_W:0]       o_mant,
   output fp_class_t             o_class
);

   logic [EXP_W-1:0]  w_exp;
   logic [MANT_W-1:0] w_frac;
   logic              w_exp_zero;
   logic              w_exp_ones;
   logic              w_frac_zero;

   assign w_exp       = i_op[EXP_W+MANT_W-1:MANT_W];
   assign w_frac      = i_op[MANT_W-1:0];
   assign w_exp_zero  = (w_exp == '0);
   assign w_exp_ones  = &w_exp;
   assign w_frac_zero = (w_frac == '0);

   always_comb begin
      o_sign  = i_op[EXP_W+MANT_W];
      o_exp   = w_exp;
      o_mant  = {1'b1, w_frac};
      o_class = NORMAL;
      if (w_exp_ones) begin
         if (w_frac_zero) begin
            o_class = INF;
         end else begin
            o_class = NAN;
         end
      end else if (w_exp_zero) begin
         if (w_frac_zero) begin
            o_class = ZERO;
            o_exp   = '0;
            o_mant  = '0;
         end else begin
`ifdef UNPACK_SUBNORM_EN
            // Subnormal value is 0.frac * 2^(1-bias), so present it with exp=1 and no hidden bit.
            o_class = SUBNORM;
            o_exp   = EXP_W'(1);
            o_mant  = {1'b0, w_frac};
`else
            o_class = ZERO;
            o_exp   = '0;
            o_mant  = '0;
`endif
         end
      end
   end

endmodule

// File: rtl/unpack_stage.sv
// Operand unpack stage: classifies both operands and buffers the result in a 2-entry skid buffer.
// Optional macro UNPACK_SUBNORM_EN (see fp_classify) selects subnormal support vs. flush-to-zero.
module unpack_stage
   import float_types_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23,
   localparam int FP_W  = 1 + EXP_W + MANT_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [FP_W-1:0]   a_i,
   input  logic [FP_W-1:0]   b_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              a_sign_o,
   output logic              b_sign_o,
   output logic [EXP_W-1:0]  a_exp_o,
   output logic [EXP_W-1:0]  b_exp_o,
   output logic [MANT_W:0]   a_mant_o,
   output logic [MANT_W:0]   b_mant_o,
   output fp_class_t         a_class_o,
   output fp_class_t         b_class_o,
   output num_status_t       num_status_o
);

   localparam int OP_W  = 1 + EXP_W + MANT_W + 1 + CLASS_W;
   localparam int PAY_W = 2 * OP_W + STATUS_W;

   logic              w_a_sign, w_b_sign;
   logic [EXP_W-1:0]  w_a_exp, w_b_exp;
   logic [MANT_W:0]   w_a_mant, w_b_mant;
   fp_class_t         w_a_class, w_b_class;
   num_status_t       w_status;
   logic [PAY_W-1:0]  w_new;
   logic              w_accept;

   logic [PAY_W-1:0]  r_out;
   logic [PAY_W-1:0]  r_skid;
   logic              r_valid;
   logic              r_skid_full;

   logic [CLASS_W-1:0]  w_a_cls_bits, w_b_cls_bits;
   logic [STATUS_W-1:0] w_st_bits;

   fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_a (
      .i_op    (a_i),
      .o_sign  (w_a_sign),
      .o_exp   (w_a_exp),
      .o_mant  (w_a_mant),
      .o_class (w_a_class)
   );

   fp_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_b (
      .i_op    (b_i),
      .o_sign  (w_b_sign),
      .o_exp   (w_b_exp),
      .o_mant  (w_b_mant),
      .o_class (w_b_class)
   );

   assign w_status = pair_status(w_a_class, w_b_class);
   assign w_new    = {w_a_sign, w_a_exp, w_a_mant, w_a_class,
                      w_b_sign, w_b_exp, w_b_mant, w_b_class, w_status};

   // Handshake: a beat moves on a rising edge only when valid and ready are both high there.
   // ready_o comes straight from the skid flag, so ready_i never reaches it combinationally.
   assign ready_o  = !r_skid_full;
   assign valid_o  = r_valid;
   assign w_accept = valid_i && ready_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid     <= 1'b0;
         r_skid_full <= 1'b0;
         r_out       <= '0;
         r_skid      <= '0;
      end else if (!r_valid || ready_i) begin
         // Output slot is free or draining this edge; the older skid entry has priority.
         if (r_skid_full) begin
            r_out       <= r_skid;
            r_valid     <= 1'b1;
            r_skid_full <= 1'b0;
         end else if (w_accept) begin
            r_out   <= w_new;
            r_valid <= 1'b1;
         end else begin
            r_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_skid      <= w_new;
         r_skid_full <= 1'b1;
      end
   end

   assign {a_sign_o, a_exp_o, a_mant_o, w_a_cls_bits,
           b_sign_o, b_exp_o, b_mant_o, w_b_cls_bits, w_st_bits} = r_out;

   assign a_class_o    = fp_class_t'(w_a_cls_bits);
   assign b_class_o    = fp_class_t'(w_b_cls_bits);
   assign num_status_o = num_status_t'(w_st_bits);

endmodule

// File: tb/tb_unpack_stage.sv
// Bench for unpack_stage: directed operand cases, skid/stall and reset scenarios, randomized stream
// against a field-level reference model, plus a half-precision instance.
module tb_unpack_stage;
  import float_types_pkg::*;

  localparam int EW  = 8;
  localparam int MW  = 23;
  localparam int FPW = 1 + EW + MW;

  typedef struct packed {
    logic        a_s;
    logic [EW-1:0] a_e;
    logic [MW:0] a_m;
    fp_class_t   a_c;
    logic        b_s;
    logic [EW-1:0] b_e;
    logic [MW:0] b_m;
    fp_class_t   b_c;
    num_status_t st;
  } exp_t;

  localparam int REC_W = $bits(exp_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic           valid_i, ready_o, valid_o, ready_i;
  logic [FPW-1:0] a_i, b_i;
  logic           a_sign_o, b_sign_o;
  logic [EW-1:0]  a_exp_o, b_exp_o;
  logic [MW:0]    a_mant_o, b_mant_o;
  fp_class_t      a_class_o, b_class_o;
  num_status_t    num_status_o;

  unpack_stage #(.EXP_W(EW), .MANT_W(MW)) u_dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .a_sign_o     (a_sign_o),
    .b_sign_o     (b_sign_o),
    .a_exp_o      (a_exp_o),
    .b_exp_o      (b_exp_o),
    .a_mant_o     (a_mant_o),
    .b_mant_o     (b_mant_o),
    .a_class_o    (a_class_o),
    .b_class_o    (b_class_o),
    .num_status_o (num_status_o)
  );

  logic        h_valid_i, h_ready_o, h_valid_o, h_ready_i;
  logic [15:0] h_a_i, h_b_i;
  logic        h_a_sign_o, h_b_sign_o;
  logic [4:0]  h_a_exp_o, h_b_exp_o;
  logic [10:0] h_a_mant_o, h_b_mant_o;
  fp_class_t   h_a_class_o, h_b_class_o;
  num_status_t h_status_o;

  unpack_stage #(.EXP_W(5), .MANT_W(10)) u_dut_h (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .valid_i      (h_valid_i),
    .ready_o      (h_ready_o),
    .a_i          (h_a_i),
    .b_i          (h_b_i),
    .valid_o      (h_valid_o),
    .ready_i      (h_ready_i),
    .a_sign_o     (h_a_sign_o),
    .b_sign_o     (h_b_sign_o),
    .a_exp_o      (h_a_exp_o),
    .b_exp_o      (h_b_exp_o),
    .a_mant_o     (h_a_mant_o),
    .b_mant_o     (h_b_mant_o),
    .a_class_o    (h_a_class_o),
    .b_class_o    (h_b_class_o),
    .num_status_o (h_status_o)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int n_drained = 0;
  logic ready_low_seen = 1'b0;
  logic [REC_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic note(input string tag, input logic ok, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  `define CHK(tag, g, w) check(tag, 64'(g), 64'(w))

  // reference model: field decode straight from the IEEE-style class rules
  function automatic void op_model(input logic [FPW-1:0] x, output logic s, output logic [EW-1:0] e,
                                   output logic [MW:0] m, output fp_class_t c);
    int unsigned     ex;
    longint unsigned fr;
    ex = int'(x[FPW-2:MW]);
    fr = longint'(x[MW-1:0]);
    s  = x[FPW-1];
    if (ex == 0 && fr == 0) begin
      c = ZERO; e = '0; m = '0;
    end else if (ex == 0) begin
`ifdef UNPACK_SUBNORM_EN
      c = SUBNORM; e = EW'(1); m = (MW+1)'(fr);
`else
      c = ZERO; e = '0; m = '0;
`endif
    end else begin
      e = EW'(ex);
      m = (MW+1)'(fr + (64'd1 << MW));
      if (ex == (2**EW) - 1) c = (fr == 0) ? INF : NAN;
      else c = NORMAL;
    end
  endfunction

  function automatic exp_t model(input logic [FPW-1:0] a, input logic [FPW-1:0] b);
    exp_t r;
    int   n_special;
    op_model(a, r.a_s, r.a_e, r.a_m, r.a_c);
    op_model(b, r.b_s, r.b_e, r.b_m, r.b_c);
    n_special = 0;
    if (r.a_c == INF || r.a_c == NAN) n_special++;
    if (r.b_c == INF || r.b_c == NAN) n_special++;
    if (n_special > 0) r.st = INF_OR_NAN;
    else if (r.a_c == ZERO && r.b_c == ZERO) r.st = ZERO_RES;
    else r.st = OK_state;
    return r;
  endfunction

  function automatic logic [FPW-1:0] rand_op();
    logic [FPW-1:0] x;
    int unsigned kind, e, f;
    kind = $urandom_range(0, 5);
    f = $urandom & ((1 << MW) - 1);
    case (kind)
      0: begin e = 0; f = 0; end
      1: begin e = 0; f = $urandom_range(1, (1 << MW) - 1); end
      2: begin e = 255; f = 0; end
      3: begin e = 255; f = $urandom_range(1, (1 << MW) - 1); end
      default: e = $urandom_range(1, 254);
    endcase
    x = {1'($urandom_range(0, 1)), EW'(e), MW'(f)};
    return x;
  endfunction

  // scoreboard: checks before the coming edge, then applies that edge's drain/accept
  always @(negedge clk) begin
    exp_t hd;
    logic exp_valid;
    logic exp_ready;
    if (rst_i) begin
      exp_q.delete();
    end else begin
      exp_valid = (exp_q.size() > 0);
      exp_ready = (exp_q.size() < 2);
      note("valid_o", valid_o === exp_valid, 64'(valid_o), 64'(exp_valid));
      note("ready_o", ready_o === exp_ready, 64'(ready_o), 64'(exp_ready));
      if (!ready_o) ready_low_seen = 1'b1;
      if (valid_o && exp_q.size() > 0) begin
        hd = exp_t'(exp_q[0]);
        note("a_sign", a_sign_o === hd.a_s, 64'(a_sign_o), 64'(hd.a_s));
        note("a_exp", a_exp_o === hd.a_e, 64'(a_exp_o), 64'(hd.a_e));
        note("a_mant", a_mant_o === hd.a_m, 64'(a_mant_o), 64'(hd.a_m));
        note("a_class", a_class_o === hd.a_c, 64'(a_class_o), 64'(hd.a_c));
        note("b_sign", b_sign_o === hd.b_s, 64'(b_sign_o), 64'(hd.b_s));
        note("b_exp", b_exp_o === hd.b_e, 64'(b_exp_o), 64'(hd.b_e));
        note("b_mant", b_mant_o === hd.b_m, 64'(b_mant_o), 64'(hd.b_m));
        note("b_class", b_class_o === hd.b_c, 64'(b_class_o), 64'(hd.b_c));
        note("status", num_status_o === hd.st, 64'(num_status_o), 64'(hd.st));
        if (ready_i) begin
          void'(exp_q.pop_front());
          n_drained++;
        end
      end
      if (valid_i && ready_o) exp_q.push_back(REC_W'(model(a_i, b_i)));
    end
  end

  // driver: holds the beat until the handshake edge
  task automatic push_pair(input logic [FPW-1:0] a, input logic [FPW-1:0] b, output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    a_i = a;
    b_i = b;
    valid_i = 1'b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = ready_o && !rst_i;
      @(posedge clk);
      #1;
      waited++;
    end
    valid_i = 1'b0;
    `CHK("push_accept", ok, 1'b1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 64 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    `CHK("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int d0;
    logic done;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; a_i = '0; b_i = '0;
    h_valid_i = 1'b0; h_ready_i = 1'b1; h_a_i = '0; h_b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    `CHK("rst_valid_o", valid_o, 1'b0);
    `CHK("rst_ready_o", ready_o, 1'b1);
    `CHK("rst_a_exp", a_exp_o, 0);
    `CHK("rst_b_mant", b_mant_o, 0);
    `CHK("rst_a_class", a_class_o, ZERO);
    `CHK("rst_b_class", b_class_o, ZERO);
    `CHK("rst_status", num_status_o, ZERO_RES);
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // 1.0 and 2.0
    push_pair(32'h3F800000, 32'h40000000, w);
    @(negedge clk);
    `CHK("d1_valid", valid_o, 1'b1);
    `CHK("d1_a_exp", a_exp_o, 8'h7F);
    `CHK("d1_a_mant", a_mant_o, 24'h800000);
    `CHK("d1_b_exp", b_exp_o, 8'h80);
    `CHK("d1_a_class", a_class_o, NORMAL);
    `CHK("d1_b_class", b_class_o, NORMAL);
    `CHK("d1_status", num_status_o, OK_state);
    @(posedge clk); #1;

    // +0 / -0
    push_pair(32'h00000000, 32'h80000000, w);
    @(negedge clk);
    `CHK("d2_a_class", a_class_o, ZERO);
    `CHK("d2_b_class", b_class_o, ZERO);
    `CHK("d2_b_sign", b_sign_o, 1'b1);
    `CHK("d2_status", num_status_o, ZERO_RES);
    @(posedge clk); #1;

    // quiet NaN with zero
    push_pair(32'h7FC00000, 32'h00000000, w);
    @(negedge clk);
    `CHK("d3_a_class", a_class_o, NAN);
    `CHK("d3_status", num_status_o, INF_OR_NAN);
    @(posedge clk); #1;

    // smallest subnormal
    push_pair(32'h00000001, 32'h3F800000, w);
    @(negedge clk);
`ifdef UNPACK_SUBNORM_EN
    `CHK("d4_a_exp", a_exp_o, 8'h01);
    `CHK("d4_a_mant", a_mant_o, 24'h000001);
    `CHK("d4_a_class", a_class_o, SUBNORM);
`else
    `CHK("d4_a_exp", a_exp_o, 8'h00);
    `CHK("d4_a_mant", a_mant_o, 24'h000000);
    `CHK("d4_a_class", a_class_o, ZERO);
`endif
    `CHK("d4_status", num_status_o, OK_state);
    @(posedge clk); #1;

    // four-beat stream with a two-cycle downstream stall after the first
    ready_low_seen = 1'b0;
    d0 = n_drained;
    fork
      begin
        push_pair(32'h3F800000, 32'hBF800000, w);
        push_pair(32'h40400000, 32'h7F800000, w);
        push_pair(32'h00400000, 32'h41200000, w);
        push_pair(32'hC2C80000, 32'h00000000, w);
      end
      begin
        @(posedge clk); #1;
        ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    wait_drain();
    `CHK("stream_ready_low", ready_low_seen, 1'b1);
    `CHK("stream_delivered", n_drained - d0, 4);

    // reset with both entries occupied
    ready_i = 1'b0;
    push_pair(32'h3F800000, 32'h40000000, w);
    push_pair(32'h7F800000, 32'hFFC00001, w);
    #2;
    rst_i = 1'b1;
    #1;
    `CHK("mid_rst_valid_o", valid_o, 1'b0);
    `CHK("mid_rst_ready_o", ready_o, 1'b1);
    `CHK("mid_rst_a_exp", a_exp_o, 0);
    `CHK("mid_rst_a_class", a_class_o, ZERO);
    `CHK("mid_rst_status", num_status_o, ZERO_RES);
    @(negedge clk);
    @(posedge clk); #1;
    rst_i = 1'b0;
    ready_i = 1'b1;
    push_pair(32'h41200000, 32'hC0400000, w);
    `CHK("first_accept_cycles", w, 1);
    wait_drain();

    // randomized stream with random downstream back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          push_pair(rand_op(), rand_op(), w);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ready_i = 1'b1;
    wait_drain();

    // half-precision instance
    `CHK("h_ready_o", h_ready_o, 1'b1);
    h_a_i = 16'h3C00; h_b_i = 16'h0000; h_valid_i = 1'b1;
    @(posedge clk); #1;
    h_valid_i = 1'b0;
    @(negedge clk);
    `CHK("h1_valid", h_valid_o, 1'b1);
    `CHK("h1_a_exp", h_a_exp_o, 5'h0F);
    `CHK("h1_a_mant", h_a_mant_o, 11'h400);
    `CHK("h1_a_class", h_a_class_o, NORMAL);
    `CHK("h1_status", h_status_o, OK_state);
    @(posedge clk); #1;
    h_a_i = 16'h7C00; h_valid_i = 1'b1;
    @(posedge clk); #1;
    h_valid_i = 1'b0;
    @(negedge clk);
    `CHK("h2_a_class", h_a_class_o, INF);
    `CHK("h2_status", h_status_o, INF_OR_NAN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
